// File: rtl/sc_layer_sequencer.sv
// Stage scheduler for the SC polar decoder: walks steps 0..2^L-1 per frame and
// issues each step with its decode layer to the PE array over valid/ready.
module sc_layer_sequencer #(
    parameter int MAX_LOG_N = 10,
    parameter int CNT_W     = MAX_LOG_N,
    parameter int LAYER_W   = $clog2(MAX_LOG_N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W-1:0] log_n_cfg,
    input  logic               abort,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [LAYER_W-1:0] step_layer,
    output logic               step_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_max;
    logic [LAYER_W-1:0] layer;
    logic [LAYER_W-1:0] l_reg;
    logic               cfg_err_q;
    logic               cfg_ok;
    logic               accept;
    logic               at_last;

    // Layer = L minus the run of 1s counted from bit L-1 downward.
    function automatic logic [LAYER_W-1:0] layer_of(input logic [CNT_W-1:0] c,
                                                    input logic [LAYER_W-1:0] l);
        logic               ones;
        logic [LAYER_W-1:0] k;
        ones = 1'b1;
        k    = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (i < int'(l)) begin
                if (ones && c[i]) k = k + LAYER_W'(1);
                else              ones = 1'b0;
            end
        end
        return l - k;
    endfunction

    always_comb begin
        cnt_max = '0;
        for (int i = 0; i < CNT_W; i++) cnt_max[i] = (i < int'(l_reg));
    end

    assign cfg_ok  = (log_n_cfg != '0) && (log_n_cfg <= LAYER_W'(MAX_LOG_N));
    assign cnt_nxt = cnt + CNT_W'(1);
    assign at_last = (cnt == cnt_max);
    assign accept  = (state == S_RUN) && step_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            layer     <= '0;
            l_reg     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            l_reg <= log_n_cfg;
                            cnt   <= '0;
                            layer <= log_n_cfg;
                            state <= S_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // abort wins over a same-cycle accept
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (accept) begin
                        if (at_last) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt_nxt;
                            layer <= layer_of(cnt_nxt, l_reg);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign step_valid = (state == S_RUN);
    assign step_cnt   = cnt;
    assign step_layer = layer;
    assign step_last  = step_valid && at_last;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_sc_layer_sequencer.sv
// Directed bench for sc_layer_sequencer: vector table plus hand sequences for
// full-length, random-stall, abort and async-reset frames.
module tb_sc_layer_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] log_n_cfg;
    logic       abort;
    logic       step_valid;
    logic       step_ready;
    logic [9:0] step_cnt;
    logic [3:0] step_layer;
    logic       step_last;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int passed = 0;
    int total  = 0;

    sc_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .log_n_cfg(log_n_cfg), .abort(abort),
        .step_valid(step_valid), .step_ready(step_ready), .step_cnt(step_cnt),
        .step_layer(step_layer), .step_last(step_last), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] cfg;
        logic       ready;
        logic       abort;
        logic       v;
        int         cnt;
        int         lay;
        logic       last;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input int c, input logic r, input logic a,
                       input logic v, input int cn, input int ly, input logic la,
                       input logic b, input logic d, input logic e);
        vec_t x;
        x = '{s, 4'(c), r, a, v, cn, ly, la, b, d, e};
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0d expected %0d", nm, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: k = how many top bits are set, found by thresholds.
    function automatic int ref_layer(input int c, input int l);
        int k;
        k = 0;
        while (k < l && c >= ((1 << l) - (1 << (l - k - 1)))) k++;
        return l - k;
    endfunction

    initial begin
        int bad;
        int idx;
        int cyc;
        int n;
        logic acc;
        int hist[11];
        int t6_lay[4];

        rst = 1'b1; start = 1'b0; log_n_cfg = '0; abort = 1'b0; step_ready = 1'b0;
        #3;
        chk("rst_outputs", int'({step_valid, step_cnt, step_layer, step_last, busy, done, cfg_err}), 0);
        #9 rst = 1'b0;

        // L=3 full frame, ready held high
        add(1, 3, 1, 0, 1, 0, 3, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 1, 3, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 2, 3, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 3, 3, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 4, 2, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 5, 2, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 6, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 7, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // rejected configs
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // L=2 with stalls, start ignored in RUN and DONE
        add(1, 2, 0, 0, 1, 0, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 1, 2, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 2, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 3, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; log_n_cfg = tbl[i].cfg;
            step_ready = tbl[i].ready; abort = tbl[i].abort;
            step();
            chk($sformatf("v%0d_valid", i), int'(step_valid), int'(tbl[i].v));
            chk($sformatf("v%0d_last", i), int'(step_last), int'(tbl[i].last));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("v%0d_done", i), int'(done), int'(tbl[i].done));
            chk($sformatf("v%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].err));
            if (tbl[i].v) begin
                chk($sformatf("v%0d_cnt", i), int'(step_cnt), tbl[i].cnt);
                chk($sformatf("v%0d_layer", i), int'(step_layer), tbl[i].lay);
            end
        end
        start = 1'b0; abort = 1'b0;

        // L=10 full frame
        foreach (hist[j]) hist[j] = 0;
        bad = 0;
        start = 1'b1; log_n_cfg = 4'd10; step_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            if (!step_valid || int'(step_cnt) != c || int'(step_layer) != ref_layer(c, 10) ||
                step_last != (c == 1023)) bad++;
            if (step_layer <= 4'd10) hist[step_layer]++;
            step();
        end
        chk("t2_seq_errs", bad, 0);
        chk("t2_done", int'(done), 1);
        chk("t2_hist_l0", hist[0], 1);
        for (int j = 1; j <= 10; j++) chk($sformatf("t2_hist_l%0d", j), hist[j], 1 << (j - 1));
        step();
        chk("t2_idle", int'(busy), 0);

        // L=4 with random stalls
        bad = 0; idx = 0; cyc = 0;
        start = 1'b1; log_n_cfg = 4'd4; step_ready = 1'b0;
        step();
        start = 1'b0;
        while (idx < 16 && cyc < 300) begin
            step_ready = 1'($urandom_range(0, 1));
            acc = step_valid && step_ready;
            if (!step_valid || int'(step_cnt) != idx || int'(step_layer) != ref_layer(idx, 4) ||
                step_last != (idx == 15) || done) bad++;
            step();
            if (acc) idx++;
            cyc++;
        end
        chk("t3_all_steps", idx, 16);
        chk("t3_seq_errs", bad, 0);
        chk("t3_done", int'(done), 1);
        step();
        chk("t3_idle", int'(busy), 0);

        // L=5 abort at cnt 9 together with ready
        step_ready = 1'b1; start = 1'b1; log_n_cfg = 4'd5;
        step();
        start = 1'b0;
        n = 0;
        while (step_cnt != 10'd9 && n < 50) begin step(); n++; end
        chk("t5_reach9", int'(step_cnt), 9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_valid", int'(step_valid), 0);
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_done", int'(done), 0);
        step();
        chk("t5_no_late_done", int'(done), 0);
        start = 1'b1; log_n_cfg = 4'd5;
        step();
        start = 1'b0;
        chk("t5_restart_cnt", int'(step_cnt), 0);
        chk("t5_restart_layer", int'(step_layer), 5);
        chk("t5_restart_valid", int'(step_valid), 1);

        // L=6 async reset at cnt 20, then L=2 frame
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1; log_n_cfg = 4'd6;
        step();
        start = 1'b0;
        n = 0;
        while (step_cnt != 10'd20 && n < 50) begin step(); n++; end
        chk("t6_reach20", int'(step_cnt), 20);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_outputs", int'({step_valid, step_cnt, step_layer, step_last, done, cfg_err}), 0);
        chk("t6_rst_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        start = 1'b1; log_n_cfg = 4'd2;
        step();
        start = 1'b0;
        t6_lay = '{2, 2, 1, 0};
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t6_cnt%0d", c), int'(step_cnt), c);
            chk($sformatf("t6_layer%0d", c), int'(step_layer), t6_lay[c]);
            step();
        end
        chk("t6_done", int'(done), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
